// File: rtl/alu_result_buffer.sv
// ---------------------------------------------------------------------------
// alu_result_buffer
//
// Registered output stage for the 4-bit ALU. Each 8-bit result F and its
// opcode S are captured through a valid/ready handshake into a small
// first-word-fall-through FIFO. Optional status flags {GT, LT, C, Z} are
// derived at capture time and stored with the entry.
//
// Optional feature macro: ALU_RESULT_FLAGS_EN
//   defined   -> flag logic and 4 flag bits per entry are compiled in
//   undefined -> no flag storage, out_flags tied to 4'b0000
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 2), default 4
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   producer has a result on in_f/in_s
//   in_ready   buffer can accept a result this cycle (count != DEPTH)
//   in_f       ALU result F (8 bits)
//   in_s       ALU opcode S (2 bits)
//   flush      synchronous clear of all stored entries (beats push/pop)
//   out_valid  head entry is valid (count != 0)
//   out_ready  consumer accepts the head entry
//   out_f      head result
//   out_s      head opcode
//   out_flags  head flags {GT, LT, C, Z}
//   count      number of stored entries
// ---------------------------------------------------------------------------
module alu_result_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [7:0]               in_f,
  input  logic [1:0]               in_s,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_f,
  output logic [1:0]               out_s,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

`ifdef ALU_RESULT_FLAGS_EN
  // Entry layout: {flags[3:0], s[1:0], f[7:0]}
  localparam int EW = 14;

  // Status flags {GT, LT, C, Z} for one ALU result.
  function automatic logic [3:0] calc_flags(input logic [7:0] f, input logic [1:0] s);
    logic z;
    logic c;
    logic lt;
    logic gt;
    z  = (f == 8'h00);
    case (s)
      2'b00:   c = f[4];       // add: carry out of the 4-bit sum
      2'b01:   c = f[7];       // sub: borrow shows as a negative difference
      2'b10:   c = |f[7:4];    // mul: product wider than 4 bits
      2'b11:   c = 1'b0;       // compare: no carry meaning
      default: c = 1'b0;
    endcase
    lt = (s == 2'b11) && (f == 8'h01);
    gt = (s == 2'b11) && (f == 8'h02);
    return {gt, lt, c, z};
  endfunction
`else
  // Entry layout: {s[1:0], f[7:0]}
  localparam int EW = 10;
`endif

  logic [EW-1:0] mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          valid_r;
  logic          ready_r;

  logic          push_s;
  logic          pop_s;
  logic [PW-1:0] wr_ptr_nxt_s;
  logic [PW-1:0] rd_ptr_nxt_s;
  logic [CW-1:0] count_nxt_s;
  logic [EW-1:0] entry_s;
  logic [EW-1:0] head_s;

  // Handshakes use only registered status, so nothing combinational
  // from the inputs reaches any output.
  assign push_s = in_valid && ready_r;
  assign pop_s  = valid_r && out_ready;

`ifdef ALU_RESULT_FLAGS_EN
  assign entry_s = {calc_flags(in_f, in_s), in_s, in_f};
`else
  assign entry_s = {in_s, in_f};
`endif

  // Next-state computation for pointers and occupancy; flush wins over all.
  always_comb begin
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    if (flush) begin
      wr_ptr_nxt_s = {PW{1'b0}};
      rd_ptr_nxt_s = {PW{1'b0}};
      count_nxt_s  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_nxt_s = wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_nxt_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nxt_s = rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_nxt_s = rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state; valid/ready are kept as registers tracking the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      valid_r  <= 1'b0;
      ready_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      valid_r  <= (count_nxt_s != {CW{1'b0}});
      ready_r  <= (count_nxt_s != FULL_COUNT);
    end
  end

  // Entry storage; not reset, and a flush cycle discards the offered data.
  always_ff @(posedge clk) begin
    if (push_s && !flush) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  // Head entry falls through straight from storage.
  assign head_s    = mem_r[rd_ptr_r];
  assign out_f     = head_s[7:0];
  assign out_s     = head_s[9:8];
`ifdef ALU_RESULT_FLAGS_EN
  assign out_flags = head_s[13:10];
`else
  assign out_flags = 4'b0000;
`endif

  assign out_valid = valid_r;
  assign in_ready  = ready_r;
  assign count     = count_r;

endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_f;
  logic [1:0] in_s;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_f;
  logic [1:0] out_s;
  logic [3:0] out_flags;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] f;
    logic [1:0] s;
    logic [3:0] fl;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_f(in_f), .in_s(in_s), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_f(out_f), .out_s(out_s),
    .out_flags(out_flags), .count(count)
  );

  // Flags as the specification defines them, straight from the result value.
  function automatic logic [3:0] exp_flags(input logic [7:0] f, input logic [1:0] s);
`ifdef ALU_RESULT_FLAGS_EN
    logic c;
    if (s == 2'd0) c = f[4];
    else if (s == 2'd1) c = f[7];
    else if (s == 2'd2) c = (f > 8'd15);
    else c = 1'b0;
    return {(s == 2'd3 && f == 8'd2), (s == 2'd3 && f == 8'd1), c, (f == 8'd0)};
`else
    return 4'b0000;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the queue model.
  task automatic check_state();
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    if (q.size() != 0) begin
      chk("out_f", 32'(out_f), 32'(q[0].f));
      chk("out_s", 32'(out_s), 32'(q[0].s));
      chk("out_flags", 32'(out_flags), 32'(q[0].fl));
    end
  endtask

  // One clock: check at the falling edge, then advance the model at the rising edge.
  task automatic step();
    logic do_push;
    logic do_pop;
    ent_t e;
    @(negedge clk);
    check_state();
    do_push = in_valid && (q.size() != DEPTH);
    do_pop  = out_ready && (q.size() != 0);
    e.f = in_f;
    e.s = in_s;
    e.fl = exp_flags(in_f, in_s);
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
    #1;
  endtask

  task automatic push_one(input logic [7:0] f, input logic [1:0] s);
    in_valid = 1'b1;
    in_f = f;
    in_s = s;
    step();
    in_valid = 1'b0;
  endtask

  logic [7:0] fill_f  [4] = '{8'h1E, 8'hFD, 8'hE1, 8'h01};
  logic [1:0] fill_s  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
`ifdef ALU_RESULT_FLAGS_EN
  logic [3:0] fill_fl [4] = '{4'b0010, 4'b0010, 4'b0010, 4'b0100};
  logic [3:0] fl_zero = 4'b0001;
  logic [3:0] fl_gt   = 4'b1000;
`else
  logic [3:0] fill_fl [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
  logic [3:0] fl_zero = 4'b0000;
  logic [3:0] fl_gt   = 4'b0000;
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_f = 8'h00; in_s = 2'b00;
    flush = 1'b0; out_ready = 1'b0;
    #13;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill to DEPTH, then one refused push.
    for (int i = 0; i < 4; i++) push_one(fill_f[i], fill_s[i]);
    chk("full_count", 32'(count), 32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    push_one(8'h55, 2'b00);
    chk("fifth_ignored_count", 32'(count), 32'd4);

    // Drain in push order.
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_f", 32'(out_f), 32'(fill_f[i]));
      chk("drain_flags", 32'(out_flags), 32'(fill_fl[i]));
      step();
    end
    chk("drained_valid", 32'(out_valid), 32'd0);

    // Simultaneous push/pop at count 2 across the pointer wrap.
    out_ready = 1'b0;
    push_one(8'hA0, 2'b00);
    push_one(8'hA1, 2'b01);
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_f = 8'hA2 + 8'(i);
      in_s = 2'(i);
      step();
      chk("stream_count", 32'(count), 32'd2);
    end
    in_valid = 1'b0;
    step();
    step();
    chk("stream_empty", 32'(count), 32'd0);

    // Flush with a concurrent push at count 3.
    out_ready = 1'b0;
    push_one(8'h11, 2'b00);
    push_one(8'h22, 2'b01);
    push_one(8'h33, 2'b10);
    flush = 1'b1;
    push_one(8'hBB, 2'b00);
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    step();
    chk("flush_stays_empty", 32'(count), 32'd0);

    // Zero and compare flags.
    push_one(8'h00, 2'b00);
    push_one(8'h02, 2'b11);
    chk("zero_flags", 32'(out_flags), 32'(fl_zero));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("gt_flags", 32'(out_flags), 32'(fl_gt));

    // Asynchronous reset between edges at count 3.
    push_one(8'h44, 2'b01);
    push_one(8'h66, 2'b10);
    chk("pre_reset_count", 32'(count), 32'd3);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_ready", 32'(in_ready), 32'd1);
    q.delete();
    #1;
    rst = 1'b0;
    push_one(8'h07, 2'b00);
    chk("post_reset_count", 32'(count), 32'd1);
    chk("post_reset_f", 32'(out_f), 32'h07);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_f      = 8'($urandom);
      in_s      = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 19) == 0);
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_buffer.md
# alu_result_buffer

Registered output stage placed directly downstream of the 4-bit ALU. It captures each 8-bit ALU result `F` together with its opcode `S` through a valid/ready handshake and holds it in a small FIFO. It can optionally derive per-operation status flags at capture time. Results are presented to the consumer in first-in-first-out order, which decouples the combinational ALU from a stalling consumer.

## Interface
- `DEPTH`, default 4: FIFO entries; must be a power of two and ≥2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: producer has a result on `in_f`/`in_s`.
- `in_ready` output 1: buffer can accept a result this cycle.
- `in_f` input 8: ALU result `F`.
- `in_s` input 2: ALU opcode `S` that produced `in_f`.
- `flush` input 1: synchronous clear of all stored entries.
- `out_valid` output 1: head entry is valid.
- `out_ready` input 1: consumer accepts the head entry.
- `out_f` output 8: head result.
- `out_s` output 2: head opcode.
- `out_flags` output 4: head flags `{GT, LT, C, Z}`.
- `count` output $clog2(DEPTH)+1: number of stored entries.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- `in_ready = (count != DEPTH)`. It does not depend on `out_ready`, so a full buffer refuses a push even in a cycle that pops.
- `out_valid = (count != 0)`. The outputs use first-word-fall-through: `out_f`, `out_s` and `out_flags` come from the head storage entry and are driven from registered state only.
- Push and pop in the same cycle:
  - both pointers advance;
  - `count` is unchanged;
  - order is preserved.
- Pointers are `$clog2(DEPTH)` bits and wrap from DEPTH-1 to 0 naturally.
- `flush`:
  - sets both pointers and `count` to 0;
  - has priority over push and pop in the same cycle;
  - discards any data presented in that cycle;
  - storage contents are not cleared.
- Flags are computed from `in_f`/`in_s` at push and stored with the entry:
  - Z = (`in_f` == 8'h00).
  - C, by opcode:
    - S=00: `in_f[4]` (carry);
    - S=01: `in_f[7]` (borrow, negative difference);
    - S=10: `|in_f[7:4]` (product exceeds 4 bits);
    - S=11: 0.
  - LT = (S==11 && `in_f`==8'h01).
  - GT = (S==11 && `in_f`==8'h02).
- Reset values:
  - `count`=0, pointers=0;
  - `out_valid`=0, `in_ready`=1;
  - storage is not reset. `out_f`, `out_s` and `out_flags` are don't-care while `out_valid`=0.

## Timing
- Latency: a result pushed at edge N is visible with `out_valid`=1 after edge N, i.e. in cycle N+1.
- There is no combinational path from inputs to outputs.
- Throughput: one push and one pop per cycle. Streaming with `out_ready`=1 holds `count` at 1.
- `rst` asserted mid-operation forces `count`=0 and `out_valid`=0 immediately, without waiting for a clock edge. The first push is accepted at the first edge after deassertion.

## Configuration
- Macro `ALU_RESULT_FLAGS_EN`:
  - Defined: flag logic and 4 flag bits per entry are compiled in; `out_flags` behaves as above.
  - Undefined: no flag storage; `out_flags` is tied to 4'b0000. All other behaviour is identical.

## Test plan
- Reset: assert `rst` → `count`=0, `out_valid`=0, `in_ready`=1.
- Fill and order, with `out_ready`=0 and DEPTH=4:
  - push (1E,00), (FD,01), (E1,10), (01,11) → `count`=4, `in_ready`=0;
  - a 5th push of (55,00) is ignored;
  - drain → outputs in push order with `out_flags` 0010, 0010, 0010, 0100.
- Simultaneous push and pop at `count`=2 for 6 cycles → `count` stays 2; outputs match push order across the pointer wrap.
- Flush and push in the same cycle with `count`=3 → `count`=0 and `out_valid`=0 next cycle; the pushed value never appears.
- Zero and compare flags: push (00,00), then (02,11) → flags 0001, then 1000. With the macro undefined → both 0000.
- Asynchronous reset at `count`=3, asserted between edges → `out_valid` falls before the next edge; after release, push (07,00) appears with `count`=1.
